// File: rtl/core_demux_pkg.sv
// Shared types, MMIO offsets and address decode for the core data-port demultiplexer.
package core_demux_pkg;

  typedef enum logic [1:0] {
    TGT_PERIPH = 2'd0,
    TGT_LOCAL  = 2'd1,
    TGT_STACK  = 2'd2,
    TGT_TCDM   = 2'd3
  } target_e;

  localparam int unsigned NUM_TARGETS = 4;

  localparam logic [7:0] MMIO_EXIT_OFS = 8'h00;
  localparam logic [7:0] MMIO_PUTC_OFS = 8'h04;

  // Priority decode: HWPE bit first, then the MMIO page, then the low 16 MiB stack.
  function automatic target_e decode_target(input logic [31:0] addr,
                                            input logic [4:0]  hwpe_bit,
                                            input logic [23:0] mmio_page);
    target_e tgt;
    if (addr[hwpe_bit]) begin
      tgt = TGT_PERIPH;
    end else if (addr[31:8] == mmio_page) begin
      tgt = TGT_LOCAL;
    end else if (addr[31:24] == 8'h00) begin
      tgt = TGT_STACK;
    end else begin
      tgt = TGT_TCDM;
    end
    return tgt;
  endfunction

endpackage

// File: rtl/core_demux_id_fifo.sv
// Small FIFO of target IDs for issued-but-unanswered requests; exposes head, tail,
// full and empty so the demux can keep responses in issue order.
module core_demux_id_fifo
  import core_demux_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic    clk_i,
  input  logic    rst_ni,
  input  logic    push_i,
  input  target_e data_i,
  input  logic    pop_i,
  output target_e head_o,
  output target_e tail_o,
  output logic    full_o,
  output logic    empty_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0] rd_ptr_reg, wr_ptr_reg;
  logic [CNT_W-1:0] count_reg, count_next;
  target_e          tail_reg;
  target_e          mem_reg [DEPTH];
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty_o = (count_reg == '0);
  assign full_o  = (count_reg == CNT_W'(DEPTH));
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign head_o  = mem_reg[rd_ptr_reg];
  // Tail is tracked separately so the same-target check never needs ptr-1 arithmetic.
  assign tail_o  = tail_reg;

  always_comb begin
    count_next = count_reg;
    if (do_push && !do_pop) begin
      count_next = count_reg + CNT_W'(1);
    end else if (!do_push && do_pop) begin
      count_next = count_reg - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
      tail_reg   <= TGT_PERIPH;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= ptr_inc(wr_ptr_reg);
        tail_reg   <= data_i;
      end
      if (do_pop) begin
        rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      end
      count_reg <= count_next;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_reg[wr_ptr_reg] <= data_i;
    end
  end

endmodule

// File: rtl/core_data_demux.sv
// Routes the core data port to HWPE periph, stack, TCDM or a local MMIO sink, and
// returns responses strictly in issue order via an outstanding target-ID FIFO.
module core_data_demux
  import core_demux_pkg::*;
#(
  parameter int unsigned HWPE_ADDR_BASE_BIT = 20,
  parameter int unsigned MAX_OUTSTANDING    = 2,
  parameter logic [31:0] MMIO_BASE          = 32'h8000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  output logic        periph_req_o,
  output logic        periph_wen_o,
  output logic [3:0]  periph_be_o,
  output logic [31:0] periph_add_o,
  output logic [31:0] periph_data_o,
  input  logic        periph_gnt_i,
  input  logic        periph_r_valid_i,
  input  logic [31:0] periph_r_data_i,
  output logic        stack_req_o,
  output logic        stack_wen_o,
  output logic [3:0]  stack_be_o,
  output logic [31:0] stack_add_o,
  output logic [31:0] stack_data_o,
  input  logic        stack_gnt_i,
  input  logic        stack_r_valid_i,
  input  logic [31:0] stack_r_data_i,
  output logic        tcdm_req_o,
  output logic        tcdm_wen_o,
  output logic [3:0]  tcdm_be_o,
  output logic [31:0] tcdm_add_o,
  output logic [31:0] tcdm_data_o,
  input  logic        tcdm_gnt_i,
  input  logic        tcdm_r_valid_i,
  input  logic [31:0] tcdm_r_data_i,
  output logic [31:0] exit_code_o,
  output logic        exit_valid_o,
  output logic        putc_valid_o,
  output logic [7:0]  putc_char_o,
  output logic        protocol_err_o
);

  localparam logic [4:0]  HWPE_BIT  = 5'(HWPE_ADDR_BASE_BIT);
  localparam logic [23:0] MMIO_PAGE = MMIO_BASE[31:8];

  target_e                sel_tgt, head_tgt, tail_tgt;
  logic                   fifo_full, fifo_empty;
  logic                   can_issue, push, pop, local_grant;
  logic [7:0]             mmio_ofs;
  logic [NUM_TARGETS-1:0] tgt_gnt, tgt_rvalid, rvalid_expected, rvalid_stray;
  logic [31:0]            tgt_rdata [NUM_TARGETS];

  logic        local_rvalid_reg;
  logic [31:0] local_rdata_reg, local_rdata_next;
  logic [31:0] exit_code_reg;
  logic        exit_valid_reg;
  logic        putc_valid_reg, putc_valid_next;
  logic [7:0]  putc_char_reg;
  logic        protocol_err_reg;

  assign sel_tgt  = decode_target(data_addr_i, HWPE_BIT, MMIO_PAGE);
  assign mmio_ofs = data_addr_i[7:0];

  // Only one target may be in flight at a time, so a target switch waits for the drain.
  assign can_issue = ~fifo_full & (fifo_empty | (tail_tgt == sel_tgt));

  assign periph_req_o  = data_req_i & can_issue & (sel_tgt == TGT_PERIPH);
  assign periph_wen_o  = ~data_we_i;
  assign periph_be_o   = data_be_i;
  assign periph_add_o  = data_addr_i;
  assign periph_data_o = data_wdata_i;

  assign stack_req_o   = data_req_i & can_issue & (sel_tgt == TGT_STACK);
  assign stack_wen_o   = ~data_we_i;
  assign stack_be_o    = data_be_i;
  assign stack_add_o   = data_addr_i;
  assign stack_data_o  = data_wdata_i;

  assign tcdm_req_o    = data_req_i & can_issue & (sel_tgt == TGT_TCDM);
  assign tcdm_wen_o    = ~data_we_i;
  assign tcdm_be_o     = data_be_i;
  assign tcdm_add_o    = {8'h00, data_addr_i[23:0]};
  assign tcdm_data_o   = data_wdata_i;

  assign tgt_gnt[TGT_PERIPH]    = periph_gnt_i;
  assign tgt_gnt[TGT_LOCAL]     = 1'b1;
  assign tgt_gnt[TGT_STACK]     = stack_gnt_i;
  assign tgt_gnt[TGT_TCDM]      = tcdm_gnt_i;

  assign tgt_rvalid[TGT_PERIPH] = periph_r_valid_i;
  assign tgt_rvalid[TGT_LOCAL]  = local_rvalid_reg;
  assign tgt_rvalid[TGT_STACK]  = stack_r_valid_i;
  assign tgt_rvalid[TGT_TCDM]   = tcdm_r_valid_i;

  assign tgt_rdata[TGT_PERIPH]  = periph_r_data_i;
  assign tgt_rdata[TGT_LOCAL]   = local_rdata_reg;
  assign tgt_rdata[TGT_STACK]   = stack_r_data_i;
  assign tgt_rdata[TGT_TCDM]    = tcdm_r_data_i;

  assign data_gnt_o  = data_req_i & can_issue & tgt_gnt[sel_tgt];
  assign push        = data_gnt_o;
  assign local_grant = push & (sel_tgt == TGT_LOCAL);

  // A response is accepted only from the target at the FIFO head; anything else is stray.
  for (genvar gi = 0; gi < NUM_TARGETS; gi++) begin : g_rsp
    assign rvalid_expected[gi] = tgt_rvalid[gi] & ~fifo_empty & (head_tgt == target_e'(gi));
    assign rvalid_stray[gi]    = tgt_rvalid[gi] & ~rvalid_expected[gi];
  end

  assign pop           = |rvalid_expected;
  assign data_rvalid_o = pop;
  assign data_rdata_o  = tgt_rdata[head_tgt];
  assign data_err_o    = 1'b0;

  core_demux_id_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .data_i  (sel_tgt),
    .pop_i   (pop),
    .head_o  (head_tgt),
    .tail_o  (tail_tgt),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    local_rdata_next = local_rdata_reg;
    putc_valid_next  = 1'b0;
    if (local_grant) begin
      local_rdata_next = (!data_we_i && (mmio_ofs == MMIO_EXIT_OFS)) ? exit_code_reg : 32'h0;
      putc_valid_next  = data_we_i && (mmio_ofs == MMIO_PUTC_OFS);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      local_rvalid_reg <= 1'b0;
      local_rdata_reg  <= 32'h0;
      exit_code_reg    <= 32'hFFFF_FFFF;
      exit_valid_reg   <= 1'b0;
      putc_valid_reg   <= 1'b0;
      putc_char_reg    <= 8'h00;
      protocol_err_reg <= 1'b0;
    end else begin
      local_rvalid_reg <= local_grant;
      local_rdata_reg  <= local_rdata_next;
      putc_valid_reg   <= putc_valid_next;
      if (putc_valid_next) begin
        putc_char_reg <= data_wdata_i[7:0];
      end
      if (local_grant && data_we_i && (mmio_ofs == MMIO_EXIT_OFS)) begin
        exit_code_reg  <= data_wdata_i;
        exit_valid_reg <= 1'b1;
      end
      protocol_err_reg <= protocol_err_reg | (|rvalid_stray);
    end
  end

  assign exit_code_o    = exit_code_reg;
  assign exit_valid_o   = exit_valid_reg;
  assign putc_valid_o   = putc_valid_reg;
  assign putc_char_o    = putc_char_reg;
  assign protocol_err_o = protocol_err_reg;

endmodule

// File: tb/tb_core_data_demux.sv
// Randomized bench for core_data_demux: a queue-based order model plus scripted target
// responders predict grants, steering, in-order responses and the MMIO sink.
module tb_core_data_demux;
  import core_demux_pkg::*;

  localparam int MAXO  = 2;
  localparam int NRAND = 600;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        data_req_i, data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i, data_wdata_i;
  logic        data_gnt_o, data_rvalid_o, data_err_o;
  logic [31:0] data_rdata_o;
  logic        periph_req_o, periph_wen_o, periph_gnt_i, periph_r_valid_i;
  logic [3:0]  periph_be_o;
  logic [31:0] periph_add_o, periph_data_o, periph_r_data_i;
  logic        stack_req_o, stack_wen_o, stack_gnt_i, stack_r_valid_i;
  logic [3:0]  stack_be_o;
  logic [31:0] stack_add_o, stack_data_o, stack_r_data_i;
  logic        tcdm_req_o, tcdm_wen_o, tcdm_gnt_i, tcdm_r_valid_i;
  logic [3:0]  tcdm_be_o;
  logic [31:0] tcdm_add_o, tcdm_data_o, tcdm_r_data_i;
  logic [31:0] exit_code_o;
  logic        exit_valid_o, putc_valid_o, protocol_err_o;
  logic [7:0]  putc_char_o;

  always #5 clk_i = ~clk_i;

  core_data_demux #(
    .HWPE_ADDR_BASE_BIT (20),
    .MAX_OUTSTANDING    (MAXO),
    .MMIO_BASE          (32'h8000_0000)
  ) dut (
    .clk_i (clk_i), .rst_ni (rst_ni),
    .data_req_i (data_req_i), .data_we_i (data_we_i), .data_be_i (data_be_i),
    .data_addr_i (data_addr_i), .data_wdata_i (data_wdata_i),
    .data_gnt_o (data_gnt_o), .data_rvalid_o (data_rvalid_o),
    .data_rdata_o (data_rdata_o), .data_err_o (data_err_o),
    .periph_req_o (periph_req_o), .periph_wen_o (periph_wen_o), .periph_be_o (periph_be_o),
    .periph_add_o (periph_add_o), .periph_data_o (periph_data_o), .periph_gnt_i (periph_gnt_i),
    .periph_r_valid_i (periph_r_valid_i), .periph_r_data_i (periph_r_data_i),
    .stack_req_o (stack_req_o), .stack_wen_o (stack_wen_o), .stack_be_o (stack_be_o),
    .stack_add_o (stack_add_o), .stack_data_o (stack_data_o), .stack_gnt_i (stack_gnt_i),
    .stack_r_valid_i (stack_r_valid_i), .stack_r_data_i (stack_r_data_i),
    .tcdm_req_o (tcdm_req_o), .tcdm_wen_o (tcdm_wen_o), .tcdm_be_o (tcdm_be_o),
    .tcdm_add_o (tcdm_add_o), .tcdm_data_o (tcdm_data_o), .tcdm_gnt_i (tcdm_gnt_i),
    .tcdm_r_valid_i (tcdm_r_valid_i), .tcdm_r_data_i (tcdm_r_data_i),
    .exit_code_o (exit_code_o), .exit_valid_o (exit_valid_o),
    .putc_valid_o (putc_valid_o), .putc_char_o (putc_char_o),
    .protocol_err_o (protocol_err_o)
  );

  // Target numbering: 0 periph, 1 local, 2 stack, 3 tcdm.
  typedef struct { int tgt; logic [31:0] addr; logic we; logic [31:0] ldata; int gcyc; } ord_t;
  typedef struct { int tgt; int t; logic [31:0] d; } rsp_t;
  typedef struct { logic [31:0] addr; logic we; logic [31:0] wdata; } req_t;

  ord_t oq[$];
  rsp_t rq[$];
  req_t dq[$];

  int          checks = 0;
  int          failures = 0;
  int          cur = 0;
  int          ntxn = 0;
  int          last_t[4];
  logic        granted = 1'b0;
  logic        rv[4];
  logic        tg[4];
  logic [31:0] rd[4];
  logic [31:0] m_exit_code = 32'hFFFF_FFFF;
  logic        m_exit_valid = 1'b0;
  logic        m_putc_valid = 1'b0;
  logic [7:0]  m_putc_char = 8'h00;
  logic        m_perr = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, obs, exp, cur);
    end
  endtask

  function automatic int ref_decode(input logic [31:0] a);
    if (a[20]) return 0;
    if (a[31:8] == 24'h80_0000) return 1;
    if (a[31:24] == 8'h00) return 2;
    return 3;
  endfunction

  task automatic add_dir(input logic [31:0] a, input logic we, input logic [31:0] wd);
    req_t r;
    r.addr = a; r.we = we; r.wdata = wd;
    dq.push_back(r);
  endtask

  task automatic gen_req();
    req_t r;
    if (dq.size() > 0) begin
      r = dq.pop_front();
    end else begin
      logic [31:0] a;
      a = $urandom;
      case ($urandom_range(0, 4))
        0: a[20] = 1'b1;
        1: begin
          a = 32'h8000_0000;
          case ($urandom_range(0, 3))
            0: a[7:0] = 8'h00;
            1: a[7:0] = 8'h04;
            2: a[7:0] = 8'h08;
            default: a[7:0] = 8'($urandom);
          endcase
        end
        2: begin a[31:24] = 8'h00; a[20] = 1'b0; end
        default: begin
          a[20] = 1'b0;
          if (a[31:24] == 8'h00) a[31:24] = 8'h1C;
        end
      endcase
      r.addr = a; r.we = 1'($urandom_range(0, 1)); r.wdata = $urandom;
    end
    data_req_i   = 1'b1;
    data_addr_i  = r.addr;
    data_we_i    = r.we;
    data_wdata_i = r.wdata;
    data_be_i    = 4'($urandom);
  endtask

  task automatic drive_targets();
    for (int k = 0; k < 4; k++) begin
      rv[k] = 1'b0;
      rd[k] = $urandom;
      tg[k] = ($urandom_range(0, 9) < 7);
    end
    for (int i = rq.size() - 1; i >= 0; i--) begin
      if (rq[i].t == cur) begin
        rv[rq[i].tgt] = 1'b1;
        rd[rq[i].tgt] = rq[i].d;
        rq.delete(i);
      end
    end
    periph_r_valid_i = rv[0]; periph_r_data_i = rd[0]; periph_gnt_i = tg[0];
    stack_r_valid_i  = rv[2]; stack_r_data_i  = rd[2]; stack_gnt_i  = tg[2];
    tcdm_r_valid_i   = rv[3]; tcdm_r_data_i   = rd[3]; tcdm_gnt_i   = tg[3];
  endtask

  task automatic cycle_check();
    int          sel, n, h;
    logic        can, gsel, exp_gnt, exp_rv, stray;
    logic [2:0]  exp_req;
    logic [31:0] obs_add, exp_add, exp_rd;
    logic [4:0]  obs_ctl;
    logic [31:0] obs_wd;
    sel = ref_decode(data_addr_i);
    n   = oq.size();
    can = (n < MAXO) && ((n == 0) || (oq[n-1].tgt == sel));
    exp_req = {data_req_i && can && (sel == 0), data_req_i && can && (sel == 2),
               data_req_i && can && (sel == 3)};
    check_eq("req_vec", {29'b0, periph_req_o, stack_req_o, tcdm_req_o}, {29'b0, exp_req});
    gsel    = (sel == 1) ? 1'b1 : tg[sel];
    exp_gnt = data_req_i && can && gsel;
    check_eq("gnt", 32'(data_gnt_o), 32'(exp_gnt));
    if (data_req_i && sel != 1) begin
      case (sel)
        0:       begin obs_add = periph_add_o; obs_ctl = {periph_wen_o, periph_be_o}; obs_wd = periph_data_o; end
        2:       begin obs_add = stack_add_o;  obs_ctl = {stack_wen_o, stack_be_o};   obs_wd = stack_data_o;  end
        default: begin obs_add = tcdm_add_o;   obs_ctl = {tcdm_wen_o, tcdm_be_o};     obs_wd = tcdm_data_o;   end
      endcase
      exp_add = (sel == 3) ? {8'h00, data_addr_i[23:0]} : data_addr_i;
      check_eq("add", obs_add, exp_add);
      check_eq("wen_be", 32'(obs_ctl), 32'({~data_we_i, data_be_i}));
      check_eq("wdata", obs_wd, data_wdata_i);
    end
    h = (n > 0) ? oq[0].tgt : -1;
    if (n == 0)      exp_rv = 1'b0;
    else if (h == 1) exp_rv = (oq[0].gcyc == cur - 1);
    else             exp_rv = rv[h];
    check_eq("rvalid", 32'(data_rvalid_o), 32'(exp_rv));
    exp_rd = 32'h0;
    if (exp_rv) begin
      exp_rd = (h == 1) ? oq[0].ldata : rd[h];
      check_eq("rdata", data_rdata_o, exp_rd);
    end
    stray = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k != 1 && rv[k] && !(n > 0 && h == k)) stray = 1'b1;
    end
    check_eq("exit_code", exit_code_o, m_exit_code);
    check_eq("exit_valid", 32'(exit_valid_o), 32'(m_exit_valid));
    check_eq("putc_valid", 32'(putc_valid_o), 32'(m_putc_valid));
    if (m_putc_valid) check_eq("putc_char", 32'(putc_char_o), 32'(m_putc_char));
    check_eq("perr", 32'(protocol_err_o), 32'(m_perr));
    check_eq("err", 32'(data_err_o), 32'h0);

    // Advance the model across the coming clock edge.
    if (exp_rv) begin
      ntxn++;
      $display("txn %0d tgt=%0d addr=%08h we=%0d rdata=%08h", ntxn, oq[0].tgt, oq[0].addr,
               oq[0].we, exp_rd);
      oq.delete(0);
    end
    m_putc_valid = 1'b0;
    if (exp_gnt) begin
      ord_t e;
      e.tgt = sel; e.addr = data_addr_i; e.we = data_we_i; e.gcyc = cur; e.ldata = 32'h0;
      if (sel == 1) begin
        if (!data_we_i && data_addr_i[7:0] == 8'h00) e.ldata = m_exit_code;
        if (data_we_i && data_addr_i[7:0] == 8'h00) begin
          m_exit_code = data_wdata_i; m_exit_valid = 1'b1;
        end
        if (data_we_i && data_addr_i[7:0] == 8'h04) begin
          m_putc_char = data_wdata_i[7:0]; m_putc_valid = 1'b1;
        end
      end else begin
        rsp_t r;
        r.tgt = sel;
        r.t   = cur + int'($urandom_range(1, 3));
        if (r.t <= last_t[sel]) r.t = last_t[sel] + 1;
        last_t[sel] = r.t;
        r.d = $urandom;
        rq.push_back(r);
      end
      oq.push_back(e);
    end
    m_perr  = m_perr | stray;
    granted = exp_gnt;
  endtask

  task automatic one_cycle(input logic allow_new);
    @(posedge clk_i);
    #1;
    cur++;
    if (granted) data_req_i = 1'b0;
    if (!data_req_i && allow_new && $urandom_range(0, 3) != 0) gen_req();
    drive_targets();
    #3;
    cycle_check();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_req"}, {29'b0, periph_req_o, stack_req_o, tcdm_req_o}, 32'h0);
    check_eq({tag, "_rvalid"}, 32'(data_rvalid_o), 32'h0);
    check_eq({tag, "_exit_code"}, exit_code_o, 32'hFFFF_FFFF);
    check_eq({tag, "_exit_valid"}, 32'(exit_valid_o), 32'h0);
    check_eq({tag, "_putc"}, {23'b0, putc_valid_o, putc_char_o}, 32'h0);
    check_eq({tag, "_perr"}, 32'(protocol_err_o), 32'h0);
  endtask

  initial begin
    rst_ni = 1'b0;
    data_req_i = 1'b0; data_we_i = 1'b0; data_be_i = 4'h0;
    data_addr_i = 32'h0; data_wdata_i = 32'h0;
    periph_gnt_i = 1'b0; periph_r_valid_i = 1'b0; periph_r_data_i = 32'h0;
    stack_gnt_i = 1'b0;  stack_r_valid_i = 1'b0;  stack_r_data_i = 32'h0;
    tcdm_gnt_i = 1'b0;   tcdm_r_valid_i = 1'b0;   tcdm_r_data_i = 32'h0;
    for (int k = 0; k < 4; k++) last_t[k] = -1;

    repeat (2) @(posedge clk_i);
    #1;
    check_reset_outputs("rst");
    @(negedge clk_i);
    rst_ni = 1'b1;

    add_dir(32'h0000_1000, 1'b0, 32'h0);
    add_dir(32'h0010_0008, 1'b1, 32'h0000_00A5);
    add_dir(32'h1C00_0040, 1'b0, 32'h0);
    add_dir(32'h1C00_0044, 1'b0, 32'h0);
    add_dir(32'h1C00_0048, 1'b0, 32'h0);
    add_dir(32'h0000_2000, 1'b0, 32'h0);
    add_dir(32'h8000_0004, 1'b1, 32'h0000_0041);
    add_dir(32'h8000_0000, 1'b1, 32'h0000_0000);
    add_dir(32'h8000_0000, 1'b0, 32'h0);

    for (int c = 0; c < NRAND; c++) one_cycle(1'b1);
    for (int c = 0; c < 200 && (oq.size() > 0 || data_req_i); c++) one_cycle(1'b0);
    check_eq("drain", 32'(oq.size()), 32'h0);

    // Stray response with nothing outstanding.
    @(posedge clk_i);
    #1;
    data_req_i = 1'b0;
    stack_r_valid_i = 1'b0; tcdm_r_valid_i = 1'b0;
    periph_r_valid_i = 1'b1;
    #3;
    check_eq("spur_rvalid", 32'(data_rvalid_o), 32'h0);
    @(posedge clk_i);
    #1;
    periph_r_valid_i = 1'b0;
    #3;
    check_eq("spur_perr", 32'(protocol_err_o), 32'h1);
    @(posedge clk_i);
    #4;
    check_eq("perr_sticky", 32'(protocol_err_o), 32'h1);

    // Reset while a stack read is outstanding.
    @(posedge clk_i);
    #1;
    data_req_i = 1'b1; data_addr_i = 32'h0000_1000; data_we_i = 1'b0; stack_gnt_i = 1'b1;
    #3;
    check_eq("mid_stack_req", 32'(stack_req_o), 32'h1);
    check_eq("mid_stack_add", stack_add_o, 32'h0000_1000);
    @(posedge clk_i);
    #1;
    data_req_i = 1'b0; stack_gnt_i = 1'b0;
    #1;
    rst_ni = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    stack_r_valid_i = 1'b1; stack_r_data_i = 32'hDEAD_BEEF;
    #3;
    check_eq("late_rvalid", 32'(data_rvalid_o), 32'h0);
    @(posedge clk_i);
    #1;
    stack_r_valid_i = 1'b0;
    #3;
    check_eq("late_perr", 32'(protocol_err_o), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
